pe_row_dbuf: RTL and testbench
==============================

Name: pe_row_dbuf

Overview:
- Weight-stationary systolic PE row with double-buffered weights.
- Each of COLS PEs holds a shadow weight that is loaded by a column-wise shift. It also holds an active weight, which is used for the MAC.
- A swap handshake drains in-flight activations, then copies shadow to active in one cycle. Weights for the next tile can therefore load while the current tile computes.
- Instances stack vertically: weight and partial-sum buses chain from row to row, and activations flow left to right.

Parameters:
- DATA_W, 24, signed activation/weight width.
- COLS, 6, number of PEs (columns) in the row; must be ≥1.
- ACC_W, 2*DATA_W, signed partial-sum width per column.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- act_in  in  DATA_W  activation entering PE0.
- act_valid_in  in  1  act_in valid.
- act_ready  out  1  row accepts an activation this cycle.
- act_out  out  DATA_W  activation leaving PE COLS-1.
- act_valid_out  out  1  act_out valid.
- w_shift_en  in  1  shift shadow weights from above.
- in_weight_above  in  DATA_W*COLS  column c occupies slice [c*DATA_W +: DATA_W].
- out_weight_below  out  DATA_W*COLS  shadow weights, registered.
- swap_req  in  1  level request to promote shadow weights to active.
- swap_done  out  1  one-cycle pulse: active weights updated.
- in_sum  in  ACC_W*COLS  partial sums from the row above.
- out_sum  out  ACC_W*COLS  registered partial sums.
- sum_valid  out  COLS  per-column out_sum updated flag.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - All shadow weights, active weights, pipeline activations, valids, out_sum and sum_valid are 0.
  - swap_done is 0.
  - FSM is in IDLE, so act_ready = 1.
- A reset asserted mid-drain or mid-swap aborts the operation. There is no swap_done pulse.
- Accept rule: an activation is accepted when act_valid_in & act_ready.
- Activation pipeline:
  - On acceptance at cycle t, PE0 registers act_in and valid at the edge ending t.
  - Each PE c+1 registers PE c's act/valid one cycle later.
  - act_out/act_valid_out are PE COLS-1's registers. Latency from acceptance is COLS cycles.
  - A bubble propagates as valid = 0.
- MAC, per PE c, on each edge:
  - If the PE's incoming valid is 1: out_sum[c] <= in_sum[c] + act * active_w[c], and sum_valid[c] <= 1.
  - Otherwise: out_sum[c] holds and sum_valid[c] <= 0.
  - The product is signed DATA_W×DATA_W giving 2*DATA_W bits, sign-extended or truncated to ACC_W.
  - The sum wraps modulo 2^ACC_W.
- Weight shift:
  - When w_shift_en = 1, shadow[c] <= in_weight_above slice c on the edge.
  - out_weight_below = shadow, so weights move one row per cycle.
  - A shift is legal in any FSM state. It never affects active weights.
- FSM:
  - IDLE: act_ready = 1. If swap_req = 1, go to DRAIN. An activation offered in that same cycle is accepted.
  - DRAIN: act_ready = 0. Stay while any pipeline valid bit (PE0..COLS-1) is 1. When all are 0, go to SWAP.
  - SWAP: act_ready = 0. On the edge, active[c] <= shadow[c] for all c simultaneously, swap_done <= 1, and go to IDLE.
  - swap_done is high for exactly the first IDLE cycle.
- Simultaneous shift and swap: if w_shift_en = 1 in the SWAP cycle, active receives the pre-shift shadow value and shadow receives the new value.
- Held request: if swap_req is still high in that first IDLE cycle, a new DRAIN starts. Requesters deassert swap_req on swap_done.
- Empty pipeline: with an already-empty pipeline, DRAIN lasts 1 cycle, so swap_done appears 3 cycles after swap_req is first seen in IDLE.

Optional Feature:
- Macro: PE_ROW_SAT_EN.
- When defined: each column's addition saturates to signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping. The product is computed at full 2*DATA_W+1 precision before clamping.
- When undefined: modulo wrap, no extra logic.

Test Plan:
All scenarios use DATA_W=8, COLS=4.
- Reset: hold rst 2 cycles -> all outputs 0, act_ready=1, swap_done=0.
- Weight load and swap:
  - Shift in weights {1,2,3,4} (col0..3), pulse swap_req.
  - Required: swap_done at cycle +3, out_weight_below = {1,2,3,4}.
  - Then send act 5 with in_sum = 10 on all columns.
  - Required: out_sum = {15,20,25,30}, sum_valid rising at cycles +1..+4, act_out = 5 at +4.
- Drain:
  - Send 3 back-to-back acts, then swap_req the next cycle.
  - Required: act_ready = 0 until swap_done; active weights change only after act_valid_out has shown all 3 acts. Results use the old weights.
- Shift during SWAP: shadow = 7, w_shift_en with new weight 9 in the SWAP cycle -> active = 7, shadow = 9.
- Arithmetic wrap vs saturate (ACC_W = 16):
  - Weight 127, act 127, in_sum = 32767.
  - Without the macro: out_sum = 32767 + 16129 mod 2^16 = -16640.
  - With PE_ROW_SAT_EN: out_sum = 32767.
  - Weight -128, act 127, in_sum = -32768 -> wrap gives 16512; saturate gives -32768.
- Reset mid-DRAIN: assert rst during DRAIN -> FSM IDLE, no swap_done, active weights 0.

Source files
------------

// File: rtl/pe_row_dbuf_if.sv
// Bus bundle for one pe_row_dbuf row: activation stream, weight chain,
// swap handshake and partial-sum chain.
interface pe_row_dbuf_if #(
    parameter int DATA_W = 24,
    parameter int COLS   = 6,
    parameter int ACC_W  = 2 * DATA_W
);
    logic [DATA_W-1:0]      act_in;
    logic                   act_valid_in;
    logic                   act_ready;
    logic [DATA_W-1:0]      act_out;
    logic                   act_valid_out;
    logic                   w_shift_en;
    logic [DATA_W*COLS-1:0] in_weight_above;
    logic [DATA_W*COLS-1:0] out_weight_below;
    logic                   swap_req;
    logic                   swap_done;
    logic [ACC_W*COLS-1:0]  in_sum;
    logic [ACC_W*COLS-1:0]  out_sum;
    logic [COLS-1:0]        sum_valid;

    modport master (
        output act_in, act_valid_in, w_shift_en, in_weight_above, swap_req, in_sum,
        input  act_ready, act_out, act_valid_out, out_weight_below, swap_done, out_sum, sum_valid
    );

    modport slave (
        input  act_in, act_valid_in, w_shift_en, in_weight_above, swap_req, in_sum,
        output act_ready, act_out, act_valid_out, out_weight_below, swap_done, out_sum, sum_valid
    );
endinterface

// File: rtl/pe_row_dbuf.sv
// Weight-stationary systolic PE row with double-buffered (shadow/active) weights.
// Optional macro PE_ROW_SAT_EN: saturating partial-sum add instead of modulo wrap.
module pe_row_dbuf #(
    parameter int DATA_W = 24,
    parameter int COLS   = 6,
    parameter int ACC_W  = 2 * DATA_W
) (
    input logic          clk,
    input logic          rst,
    pe_row_dbuf_if.slave bus
);
`ifdef PE_ROW_SAT_EN
    localparam int PROD_W = 2 * DATA_W + 1;
    localparam int WIDE_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
`else
    localparam int PROD_W = 2 * DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

    state_t                   state;
    logic                     act_ready_r;
    logic                     swap_done_r;
    logic                     accept;
    logic signed [DATA_W-1:0] shadow_w [COLS];
    logic signed [DATA_W-1:0] active_w [COLS];
    logic signed [DATA_W-1:0] act_p    [COLS];
    logic signed [DATA_W-1:0] act_into [COLS];
    logic signed [ACC_W-1:0]  sum_p    [COLS];
    logic [COLS-1:0]          vld_p;
    logic [COLS-1:0]          vld_into;
    logic [COLS-1:0]          sum_vld_p;

    function automatic logic signed [ACC_W-1:0] mac_acc(
        input logic signed [ACC_W-1:0]  psum,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] w
    );
        logic signed [PROD_W-1:0] prod;
`ifdef PE_ROW_SAT_EN
        logic signed [WIDE_W-1:0] wide;
        prod = PROD_W'(a) * PROD_W'(w);
        wide = WIDE_W'(psum) + WIDE_W'(prod);
        // In range iff every bit from the ACC_W sign position upward agrees.
        if ((&wide[WIDE_W-1:ACC_W-1]) || !(|wide[WIDE_W-1:ACC_W-1]))
            return wide[ACC_W-1:0];
        else if (wide[WIDE_W-1])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
`else
        prod = PROD_W'(a) * PROD_W'(w);
        return psum + ACC_W'(prod);
`endif
    endfunction

    always_comb begin
        accept      = bus.act_valid_in & act_ready_r;
        act_into[0] = bus.act_in;
        vld_into    = '0;
        vld_into[0] = accept;
        for (int c = 1; c < COLS; c++) begin
            act_into[c] = act_p[c-1];
            vld_into[c] = vld_p[c-1];
        end
    end

    // PE stage registers: activation hop, MAC, shadow weight shift
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p     <= '0;
            sum_vld_p <= '0;
            for (int c = 0; c < COLS; c++) begin
                shadow_w[c] <= '0;
                act_p[c]    <= '0;
                sum_p[c]    <= '0;
            end
        end else begin
            vld_p     <= vld_into;
            sum_vld_p <= vld_into;
            for (int c = 0; c < COLS; c++) begin
                act_p[c] <= act_into[c];
                if (bus.w_shift_en)
                    shadow_w[c] <= $signed(bus.in_weight_above[c*DATA_W +: DATA_W]);
                if (vld_into[c])
                    sum_p[c] <= mac_acc($signed(bus.in_sum[c*ACC_W +: ACC_W]),
                                        act_into[c], active_w[c]);
            end
        end
    end

    // Swap controller; active weights only ever change on the SWAP edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            act_ready_r <= 1'b1;
            swap_done_r <= 1'b0;
            for (int c = 0; c < COLS; c++)
                active_w[c] <= '0;
        end else begin
            swap_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.swap_req) begin
                        state       <= DRAIN;
                        act_ready_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!(|vld_p))
                        state <= SWAP;
                end
                SWAP: begin
                    for (int c = 0; c < COLS; c++)
                        active_w[c] <= shadow_w[c];
                    swap_done_r <= 1'b1;
                    act_ready_r <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    act_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.act_ready     = act_ready_r;
    assign bus.swap_done     = swap_done_r;
    assign bus.act_out       = act_p[COLS-1];
    assign bus.act_valid_out = vld_p[COLS-1];
    assign bus.sum_valid     = sum_vld_p;

    for (genvar g = 0; g < COLS; g++) begin : g_pack
        assign bus.out_weight_below[g*DATA_W +: DATA_W] = shadow_w[g];
        assign bus.out_sum[g*ACC_W +: ACC_W]            = sum_p[g];
    end
endmodule

// File: tb/tb_pe_row_dbuf.sv
// Scoreboard bench for pe_row_dbuf (DATA_W=8, COLS=4, ACC_W=16); honours PE_ROW_SAT_EN.
module tb_pe_row_dbuf;
    localparam int DATA_W = 8;
    localparam int COLS   = 4;
    localparam int ACC_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pe_row_dbuf_if #(.DATA_W(DATA_W), .COLS(COLS), .ACC_W(ACC_W)) bus ();

    pe_row_dbuf #(.DATA_W(DATA_W), .COLS(COLS), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint model_shadow [COLS];
    longint model_active [COLS];
    longint cur_sum      [COLS];
    longint exp_q        [COLS][$];
    longint act_q        [$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic longint model_mac(input longint s, input longint a, input longint w);
        longint r;
        r = s + a * w;
`ifdef PE_ROW_SAT_EN
        if (r > (longint'(1) <<< (ACC_W-1)) - 1) r = (longint'(1) <<< (ACC_W-1)) - 1;
        if (r < -(longint'(1) <<< (ACC_W-1)))    r = -(longint'(1) <<< (ACC_W-1));
`else
        r = r & ((longint'(1) <<< ACC_W) - 1);
        if (r >= (longint'(1) <<< (ACC_W-1))) r = r - (longint'(1) <<< ACC_W);
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sums(input longint s0, input longint s1, input longint s2, input longint s3);
        longint s [COLS];
        s = '{s0, s1, s2, s3};
        for (int c = 0; c < COLS; c++) begin
            cur_sum[c] = s[c];
            bus.in_sum[c*ACC_W +: ACC_W] = s[c][ACC_W-1:0];
        end
    endtask

    task automatic load_shadow(input longint w0, input longint w1, input longint w2, input longint w3);
        longint w [COLS];
        w = '{w0, w1, w2, w3};
        for (int c = 0; c < COLS; c++) begin
            bus.in_weight_above[c*DATA_W +: DATA_W] = w[c][DATA_W-1:0];
            model_shadow[c] = w[c];
        end
        bus.w_shift_en = 1'b1;
        tick();
        bus.w_shift_en = 1'b0;
        for (int c = 0; c < COLS; c++)
            chk($sformatf("wbelow%0d", c), $signed(bus.out_weight_below[c*DATA_W +: DATA_W]), w[c]);
    endtask

    task automatic send_act(input longint a);
        bus.act_in       = a[DATA_W-1:0];
        bus.act_valid_in = 1'b1;
        chk("ready_accept", bus.act_ready, 1);
        for (int c = 0; c < COLS; c++)
            exp_q[c].push_back(model_mac(cur_sum[c], a, model_active[c]));
        act_q.push_back(a);
        tick();
        bus.act_valid_in = 1'b0;
    endtask

    task automatic do_swap(input int exp_lat);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.swap_req = 1'b1;
        while (!done && n < 40) begin
            tick();
            n++;
            if (bus.swap_done) begin
                done = 1'b1;
                bus.swap_req = 1'b0;
            end else begin
                chk("ready_low_in_swap", bus.act_ready, 0);
            end
        end
        if (!done) begin
            chk("swap_timeout", 0, 1);
            bus.swap_req = 1'b0;
        end else begin
            chk("ready_after_swap", bus.act_ready, 1);
            chk("swap_latency", n, exp_lat);
            model_active = model_shadow;
            tick();
            chk("swap_done_pulse", bus.swap_done, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < COLS; c++) begin
                if (bus.sum_valid[c]) begin
                    if (exp_q[c].size() == 0) chk($sformatf("sum%0d_unexpected", c), 1, 0);
                    else chk($sformatf("sum%0d", c), $signed(bus.out_sum[c*ACC_W +: ACC_W]),
                             exp_q[c].pop_front());
                end
            end
            if (bus.act_valid_out) begin
                if (act_q.size() == 0) chk("act_out_unexpected", 1, 0);
                else chk("act_out", $signed(bus.act_out), act_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint exp_sum [COLS];
        int seen;
        int n;
        bit done;

        bus.act_in = '0;
        bus.act_valid_in = 1'b0;
        bus.w_shift_en = 1'b0;
        bus.in_weight_above = '0;
        bus.swap_req = 1'b0;
        bus.in_sum = '0;
        for (int c = 0; c < COLS; c++) begin
            model_shadow[c] = 0;
            model_active[c] = 0;
            cur_sum[c] = 0;
        end

        // Reset state
        rst = 1'b1;
        idle(2);
        chk("rst_act_ready", bus.act_ready, 1);
        chk("rst_swap_done", bus.swap_done, 0);
        chk("rst_act_valid_out", bus.act_valid_out, 0);
        chk("rst_act_out", bus.act_out, 0);
        chk("rst_sum_valid", bus.sum_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_wbelow", bus.out_weight_below, 0);
        rst = 1'b0;
        tick();

        // Weight load, swap, single activation
        load_shadow(1, 2, 3, 4);
        do_swap(3);
        set_sums(10, 10, 10, 10);
        send_act(5);
        for (int k = 1; k <= COLS; k++) begin
            chk($sformatf("sum_valid_t%0d", k), bus.sum_valid, longint'(1) << (k-1));
            if (k < COLS) tick();
        end
        chk("act_valid_out_t4", bus.act_valid_out, 1);
        chk("act_out_t4", $signed(bus.act_out), 5);
        exp_sum = '{15, 20, 25, 30};
        for (int c = 0; c < COLS; c++)
            chk($sformatf("out_sum_basic%0d", c), $signed(bus.out_sum[c*ACC_W +: ACC_W]), exp_sum[c]);
        idle(2);

        // Drain: three back-to-back acts, swap requested right after
        load_shadow(2, -3, 4, -5);
        set_sums(100, 100, 100, 100);
        send_act(1);
        send_act(-2);
        send_act(3);
        bus.swap_req = 1'b1;
        seen = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (bus.act_valid_out) seen++;
            if (bus.swap_done) begin
                done = 1'b1;
                bus.swap_req = 1'b0;
                bus.act_valid_in = 1'b0;
                chk("drain_outs_before_swap", seen, 3);
            end else begin
                chk("drain_ready_low", bus.act_ready, 0);
                bus.act_in = 8'd99;
                bus.act_valid_in = 1'b1;
            end
        end
        if (!done) begin
            chk("drain_swap_timeout", 0, 1);
            bus.swap_req = 1'b0;
            bus.act_valid_in = 1'b0;
        end
        model_active = model_shadow;
        tick();
        set_sums(0, 0, 0, 0);
        send_act(2);
        idle(6);

        // Shift lands on the SWAP edge: active takes old shadow
        load_shadow(7, 7, 7, 7);
        bus.swap_req = 1'b1;
        tick();
        chk("ss_drain_done", bus.swap_done, 0);
        tick();
        chk("ss_swap_ready", bus.act_ready, 0);
        for (int c = 0; c < COLS; c++) bus.in_weight_above[c*DATA_W +: DATA_W] = 8'd9;
        bus.w_shift_en = 1'b1;
        tick();
        bus.w_shift_en = 1'b0;
        bus.swap_req = 1'b0;
        chk("ss_swap_done", bus.swap_done, 1);
        for (int c = 0; c < COLS; c++) begin
            chk($sformatf("ss_shadow%0d", c), $signed(bus.out_weight_below[c*DATA_W +: DATA_W]), 9);
            model_active[c] = 7;
            model_shadow[c] = 9;
        end
        send_act(1);
        idle(6);
        for (int c = 0; c < COLS; c++)
            chk($sformatf("ss_active%0d", c), $signed(bus.out_sum[c*ACC_W +: ACC_W]), 7);

        // Overflow corners
        load_shadow(127, -128, 0, 0);
        do_swap(3);
        set_sums(32767, -32768, 0, 0);
        send_act(127);
        idle(6);
`ifdef PE_ROW_SAT_EN
        chk("ovf_pos", $signed(bus.out_sum[0 +: ACC_W]), 32767);
        chk("ovf_neg", $signed(bus.out_sum[ACC_W +: ACC_W]), -32768);
`else
        chk("ovf_pos", $signed(bus.out_sum[0 +: ACC_W]), -16640);
        chk("ovf_neg", $signed(bus.out_sum[ACC_W +: ACC_W]), 16512);
`endif

        // Reset while draining aborts the swap
        set_sums(5, 5, 5, 5);
        send_act(1);
        bus.swap_req = 1'b1;
        tick();
        chk("rd_in_drain", bus.act_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.swap_req = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            exp_q[c].delete();
            model_active[c] = 0;
            model_shadow[c] = 0;
        end
        act_q.delete();
        chk("rd_ready", bus.act_ready, 1);
        chk("rd_act_valid_out", bus.act_valid_out, 0);
        chk("rd_sum_valid", bus.sum_valid, 0);
        chk("rd_wbelow", bus.out_weight_below, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rd_no_swap_done", bus.swap_done, 0);
            tick();
        end
        send_act(3);
        idle(6);
        for (int c = 0; c < COLS; c++)
            chk($sformatf("rd_active_zero%0d", c), $signed(bus.out_sum[c*ACC_W +: ACC_W]), 5);

        for (int c = 0; c < COLS; c++)
            chk($sformatf("q_empty%0d", c), exp_q[c].size(), 0);
        chk("act_q_empty", act_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
